spi_reg_bridge: RTL and testbench



---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_reg_bridge_if.sv | 57 +++++
 rtl/sync_2ff.sv | 36 +++
 rtl/spi_reg_bridge.sv | 149 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI byte-stream to register-bus bridge.
//   - FSM state encodings (plain localparam constants)
//   - Command header bit positions
//   - Default transmit fill byte
// No ports.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_CMD    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR     = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_REQ = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_CAP = 3'd4;
  localparam logic [STATE_W-1:0] ST_RD     = 3'd5;

  // Command byte bit 7 selects read (1) or write (0)
  localparam int CMD_RD_BIT = 7;

  localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge_if
// Bundles the byte-engine handshake and the register-bus signals of the bridge.
//   master modport : SPI byte engine + register file side (drives cs, rx_*, reg_rdata)
//   slave  modport : the bridge itself (drives tx_data, reg_*, frame_err)
// Signals:
//   cs        chip select, active low, asynchronous to the system clock
//   rx_ack    one-cycle pulse, rx_data holds a complete byte
//   rx_data   received byte
//   tx_data   byte for the next slave byte slot
//   reg_addr  register address
//   reg_wr_en one-cycle write strobe, reg_wdata valid with it
//   reg_rd_en one-cycle read strobe, reg_rdata valid one cycle later
//   frame_err one-cycle pulse on a frame with no data bytes
// -----------------------------------------------------------------------------
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7
);

  logic              cs;
  logic              rx_ack;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wdata;
  logic              reg_rd_en;
  logic [7:0]        reg_rdata;
  logic              frame_err;

  modport master (
    output cs,
    output rx_ack,
    output rx_data,
    output reg_rdata,
    input  tx_data,
    input  reg_addr,
    input  reg_wr_en,
    input  reg_wdata,
    input  reg_rd_en,
    input  frame_err
  );

  modport slave (
    input  cs,
    input  rx_ack,
    input  rx_data,
    input  reg_rdata,
    output tx_data,
    output reg_addr,
    output reg_wr_en,
    output reg_wdata,
    output reg_rd_en,
    output frame_err
  );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser with a configurable reset value.
// Ports:
//   i_clk  destination clock
//   i_rst  asynchronous active-high reset (flops load RST_VAL)
//   i_d    asynchronous input
//   o_q    synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage resynchronisation chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Converts the received-byte stream of an SPI slave byte engine into register
// bus transactions. A frame (cs low) starts with a command byte
// (bit7 = read, low ADDR_W bits = start address) followed by data bytes that
// are written, or byte slots that are filled with prefetched read data.
// Ports:
//   i_sys_clk  system clock
//   i_sys_rst  asynchronous active-high reset
//   bus        spi_reg_bridge_if.slave (byte handshake + register bus)
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic       AUTO_INC  = 1'b1,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  spi_reg_bridge_if.slave     bus
);

  logic                w_cs_s;
  logic                w_cs_fall;
  logic                w_data_ack;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic                w_unused_rx;

  logic                r_cs_d;
  logic [STATE_W-1:0]  r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [7:0]          r_tx_data;
  logic [7:0]          r_wdata;
  logic                r_wr_en;
  logic                r_rd_en;
  logic                r_frame_err;
  logic                r_data_seen;

  // cs idles high, so the synchroniser resets to 1 to avoid a false frame start
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .i_clk (i_sys_clk),
    .i_rst (i_sys_rst),
    .i_d   (bus.cs),
    .o_q   (w_cs_s)
  );

  assign w_cs_fall  = r_cs_d & ~w_cs_s;
  assign w_cmd_addr = bus.rx_data[ADDR_W-1:0];
  assign w_addr_inc = r_addr + ADDR_W'(AUTO_INC);
  // Only acks taken in ST_WR / ST_RD count as data bytes of the frame
  assign w_data_ack = bus.rx_ack && ((r_state == ST_WR) || (r_state == ST_RD));
  // Header bits between CMD_RD_BIT and the address field are don't-care
  assign w_unused_rx = ^bus.rx_data;

  // Frame FSM, address pointer and all registered bus outputs
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_cs_d      <= 1'b1;
      r_state     <= ST_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_reg_addr  <= {ADDR_W{1'b0}};
      r_tx_data   <= FILL_BYTE;
      r_wdata     <= 8'h00;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_data_seen <= 1'b0;
    end else begin
      r_cs_d      <= w_cs_s;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_tx_data   <= FILL_BYTE;
          r_data_seen <= 1'b0;
          if (w_cs_fall) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.rx_ack) begin
            r_addr <= w_cmd_addr;
            if (bus.rx_data[CMD_RD_BIT]) begin
              // Launch the prefetch so the first read byte is ready for the next slot
              r_reg_addr <= w_cmd_addr;
              r_rd_en    <= 1'b1;
              r_state    <= ST_RD_REQ;
            end else begin
              r_state <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (bus.rx_ack) begin
            r_wr_en     <= 1'b1;
            r_reg_addr  <= r_addr;
            r_wdata     <= bus.rx_data;
            r_addr      <= w_addr_inc;
            r_data_seen <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          // reg_rd_en is high in this state; rx_ack here is ignored
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          r_tx_data <= bus.reg_rdata;
          r_state   <= ST_RD;
        end
        ST_RD: begin
          if (bus.rx_ack) begin
            r_addr      <= w_addr_inc;
            r_reg_addr  <= w_addr_inc;
            r_rd_en     <= 1'b1;
            r_data_seen <= 1'b1;
            r_state     <= ST_RD_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Frame end overrides the state actions above; a coincident write still issues
      if (w_cs_s && (r_state != ST_IDLE)) begin
        r_state     <= ST_IDLE;
        r_rd_en     <= 1'b0;
        r_tx_data   <= FILL_BYTE;
        r_frame_err <= (r_state == ST_CMD) || (!r_data_seen && !w_data_ack);
      end
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wr_en = r_wr_en;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_rd_en = r_rd_en;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Self-checking bench for spi_reg_bridge. Two instances share the byte stream:
// dut_a with address auto-increment, dut_b with a fixed address. A small
// register-file model answers reads; expected strobes and transmit bytes are
// queued when stimulus is driven and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       sel_b;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];
  logic [7:0]  tx_q[$];

  logic [7:0] mem_a [0:127];
  logic [7:0] mem_b [0:127];

  spi_reg_bridge_if #(.ADDR_W(7)) bus_a ();
  spi_reg_bridge_if #(.ADDR_W(7)) bus_b ();

  spi_reg_bridge #(.ADDR_W(7), .AUTO_INC(1'b1), .FILL_BYTE(8'hFF)) dut_a (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus_a)
  );

  spi_reg_bridge #(.ADDR_W(7), .AUTO_INC(1'b0), .FILL_BYTE(8'hFF)) dut_b (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus_b)
  );

  // Only the selected instance sees chip select low
  assign bus_a.cs      = sel_b ? 1'b1 : cs;
  assign bus_b.cs      = sel_b ? cs : 1'b1;
  assign bus_a.rx_ack  = rx_ack;
  assign bus_b.rx_ack  = rx_ack;
  assign bus_a.rx_data = rx_data;
  assign bus_b.rx_data = rx_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file models: read data one cycle after the strobe, writes stored
  always @(posedge clk) begin
    if (rst) begin
      bus_a.reg_rdata <= 8'h00;
    end else begin
      if (bus_a.reg_rd_en) bus_a.reg_rdata <= mem_a[bus_a.reg_addr];
      if (bus_a.reg_wr_en) mem_a[bus_a.reg_addr] <= bus_a.reg_wdata;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bus_b.reg_rdata <= 8'h00;
    end else begin
      if (bus_b.reg_rd_en) bus_b.reg_rdata <= mem_b[bus_b.reg_addr];
      if (bus_b.reg_wr_en) mem_b[bus_b.reg_addr] <= bus_b.reg_wdata;
    end
  end

  task automatic mon_wr(input logic [6:0] addr, input logic [7:0] data);
    if (wr_q.size() == 0) check_eq("wr_unexpected", 32'({addr, data}), 32'h7FFF_FFFF);
    else check_eq("wr_addr_data", 32'({addr, data}), 32'(wr_q.pop_front()));
  endtask

  task automatic mon_rd(input logic [6:0] addr);
    if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(addr), 32'h7FFF_FFFF);
    else check_eq("rd_addr", 32'(addr), 32'(rd_q.pop_front()));
  endtask

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus_a.reg_wr_en) mon_wr(bus_a.reg_addr, bus_a.reg_wdata);
    if (bus_b.reg_wr_en) mon_wr(bus_b.reg_addr, bus_b.reg_wdata);
    if (bus_a.reg_rd_en) mon_rd(bus_a.reg_addr);
    if (bus_b.reg_rd_en) mon_rd(bus_b.reg_addr);
    if (bus_a.frame_err) err_cnt = err_cnt + 1;
    if (bus_b.frame_err) err_cnt = err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] cur_tx();
    return sel_b ? bus_b.tx_data : bus_a.tx_data;
  endfunction

  // One byte slot: slave loads tx_data at slot start, then delivers the byte
  task automatic send_byte(input logic [7:0] b);
    if (tx_q.size() > 0) check_eq("tx_data", 32'(cur_tx()), 32'(tx_q.pop_front()));
    tick(15);
    rx_data = b;
    rx_ack  = 1'b1;
    tick(1);
    rx_ack  = 1'b0;
    tick(4);
  endtask

  task automatic start_frame();
    err_cnt = 0;
    cs = 1'b0;
    tick(4);
  endtask

  task automatic end_frame(input int exp_err);
    cs = 1'b1;
    tick(8);
    check_eq("frame_err", 32'(err_cnt), 32'(exp_err));
    check_eq("tx_idle", 32'(cur_tx()), 32'hFF);
    check_eq("wr_pending", 32'(wr_q.size()), 32'd0);
    check_eq("rd_pending", 32'(rd_q.size()), 32'd0);
    check_eq("tx_pending", 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    cs      = 1'b1;
    rx_ack  = 1'b0;
    rx_data = 8'h00;
    sel_b   = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[7'h10] = 8'h3C;
    mem_a[7'h11] = 8'hC3;
    mem_a[7'h12] = 8'h5A;
    mem_a[7'h30] = 8'hA5;
    mem_b[7'h05] = 8'h77;

    tick(3);
    check_eq("rst_tx", 32'(bus_a.tx_data), 32'hFF);
    check_eq("rst_addr", 32'(bus_a.reg_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus_a.reg_wdata), 32'd0);
    check_eq("rst_wr_en", 32'(bus_a.reg_wr_en), 32'd0);
    check_eq("rst_rd_en", 32'(bus_a.reg_rd_en), 32'd0);
    check_eq("rst_err", 32'(bus_a.frame_err), 32'd0);
    rst = 1'b0;
    tick(4);

    // Write frame with auto-increment
    start_frame();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'hFF);
    wr_q.push_back({7'h05, 8'hAA});
    wr_q.push_back({7'h06, 8'h55});
    send_byte(8'h05);
    send_byte(8'hAA);
    send_byte(8'h55);
    end_frame(0);

    // Read frame: prefetch 0x10, 0x11, 0x12
    start_frame();
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    rd_q.push_back(7'h10);
    rd_q.push_back(7'h11);
    rd_q.push_back(7'h12);
    send_byte(8'h90);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("tx_third_prefetch", 32'(bus_a.tx_data), 32'h5A);
    end_frame(0);

    // Address wrap 7F -> 00 -> 01
    start_frame();
    wr_q.push_back({7'h7F, 8'h01});
    wr_q.push_back({7'h00, 8'h02});
    wr_q.push_back({7'h01, 8'h03});
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    end_frame(0);

    // Fixed address instance: writes, then reads, all at one address
    sel_b = 1'b1;
    tick(4);
    start_frame();
    wr_q.push_back({7'h03, 8'h11});
    wr_q.push_back({7'h03, 8'h22});
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    end_frame(0);
    check_eq("b_mem3", 32'(mem_b[7'h03]), 32'h22);

    start_frame();
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h77);
    rd_q.push_back(7'h05);
    rd_q.push_back(7'h05);
    send_byte(8'h85);
    send_byte(8'h00);
    end_frame(0);
    sel_b = 1'b0;
    tick(4);

    // Abort right after a write command byte
    start_frame();
    tx_q.push_back(8'hFF);
    send_byte(8'h20);
    end_frame(1);

    // Abort with no byte at all (frame ends in ST_CMD)
    start_frame();
    tick(4);
    end_frame(1);

    // Reset asserted while the bridge waits for read data
    start_frame();
    rd_q.push_back(7'h30);
    rx_data = 8'hB0;
    rx_ack  = 1'b1;
    tick(1);
    rx_ack  = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(bus_a.tx_data), 32'hFF);
    check_eq("midrst_addr", 32'(bus_a.reg_addr), 32'd0);
    check_eq("midrst_rd_en", 32'(bus_a.reg_rd_en), 32'd0);
    check_eq("midrst_wr_en", 32'(bus_a.reg_wr_en), 32'd0);
    check_eq("midrst_err", 32'(bus_a.frame_err), 32'd0);
    cs = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_eq("midrst_rd_pending", 32'(rd_q.size()), 32'd0);

    // Next frame after the reset decodes normally
    start_frame();
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hC3);
    rd_q.push_back(7'h11);
    rd_q.push_back(7'h12);
    send_byte(8'h91);
    send_byte(8'h00);
    end_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
